clk_div_sequencer: RTL
======================

// Module: clk_div_sequencer
// PURPOSE
//  Owns the programmable divider that produces the FSM clock-enable tick.
//  Arbitrates divider-threshold change requests from two requesters: 0 = host wire-in, 1 = I2C/config FSM.
//  Applies each change only at a period boundary, then holds div_ready low for a settle window.
//  Downstream FSMs run only when tick && div_ready, so they never see a runt period.
// PARAMETERS
//  WIDTH        24      width of divider threshold and counter
//  RESET_THR    24'd100 threshold loaded at reset
//  SETTLE_TICKS 4       ticks div_ready stays low after a change (>=1)
// PORTS
//  clk        in   1      system clock (single domain)
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   2      change request per requester; level, held until ack
//  thr0       in   WIDTH  requested threshold, requester 0
//  thr1       in   WIDTH  requested threshold, requester 1
//  ack        out  2      one-cycle pulse: request granted and applied
//  tick       out  1      one-cycle pulse every (cur_thr+1) clk cycles
//  cur_thr    out  WIDTH  threshold currently in force
//  div_ready  out  1      high = tick spacing is stable
//  busy       out  1      high outside IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): cnt=0, cur_thr=RESET_THR, tick=0, ack=0,
//   div_ready=1, busy=0, rr_last=1 (requester 0 wins first tie), state=IDLE.
//  Counter: runs in every state.
//   cnt>=cur_thr -> cnt<=0 and tick=1 that cycle; else cnt<=cnt+1, tick=0.
//   '>=' covers cnt above a newly lowered threshold: wrap on the next cycle.
//   cur_thr=0 -> tick every cycle.
//  FSM states: IDLE, WAIT_WRAP, SETTLE.
//   IDLE: if any req, grant one.
//    Single request: grant that requester.
//    Both: grant the one != rr_last (round-robin).
//    Latch grant id, its thr into pend_thr, set rr_last=grant, go WAIT_WRAP.
//    Request and grant happen in the same cycle; busy=1 from the next cycle.
//   WAIT_WRAP: on the cycle with tick=1:
//    cur_thr<=pend_thr, cnt<=0, ack[grant]=1 (one cycle), div_ready<=0,
//    settle_cnt<=SETTLE_TICKS-1, go SETTLE.
//    The new threshold governs the very next period.
//   SETTLE: on each tick: if settle_cnt==0 -> div_ready<=1, go IDLE; else settle_cnt-1.
//  Requests arriving while busy: ignored until IDLE; the requester keeps req high.
//  Requester drops req before ack: change still completes, ack still pulses; no abort.
//  pend_thr==cur_thr: full sequence still runs (ack + settle).
//  A req still high in the cycle ack fires is not a new request.
//   Requester must deassert within 1 cycle of ack.
//   A new grant is taken only from IDLE (>=1 cycle after SETTLE exits).
//  Reset mid-sequence: pending change discarded, cur_thr=RESET_THR, no ack.
//  Widths: cnt and settle_cnt unsigned, no overflow (cnt<=cur_thr); settle_cnt=clog2(SETTLE_TICKS+1).
// STRUCTURE
//  Shared package/header: state encodings (IDLE=2'd0, WAIT_WRAP=2'd1, SETTLE=2'd2), requester ids.
//  One sub-module: clk_div_counter (cnt, cur_thr compare, tick); top holds arbiter+FSM.
// TESTING
//  1 Reset, no req, RESET_THR=100 -> tick every 101 cycles; div_ready=1; cur_thr=100.
//  2 req[0], thr0=9, at cnt=50 -> ack[0] on next wrap (cycle 101 of period).
//    Then ticks every 10 cycles; div_ready low for 4 ticks (40 cycles) then high.
//  3 req=2'b11 in the same cycle, thr0=5, thr1=7 -> requester 0 first (ack[0]).
//    Requester 1 served after SETTLE; cur_thr ends at 7.
//    Next simultaneous pair -> requester 1 wins (round-robin alternates).
//  4 thr0=0 -> after ack, tick high every cycle; settle lasts exactly 4 cycles.
//  5 rst_n low during SETTLE after a change to 9 -> no further ack.
//    cur_thr=100, div_ready=1 immediately; first tick 101 cycles after release.
//  6 cur_thr=3, req[1] with thr1=3 -> ack[1] at the next wrap; div_ready low 4 ticks; spacing unchanged.

Source files
------------

// File: rtl/clk_div_sequencer_pkg.sv
// clk_div_sequencer_pkg: FSM state encodings and requester ids for the divider sequencer.
package clk_div_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        SETTLE    = 2'd2
    } state_t;
    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CFG  = 1'b1;
endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: free-running divider; tick whenever cnt reaches or passes the threshold in force.
module clk_div_counter #(
    parameter int               WIDTH     = 24,
    parameter logic [WIDTH-1:0] RESET_THR = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_thr,
    output logic             tick,
    output logic [WIDTH-1:0] cur_thr
);
    logic [WIDTH-1:0] cnt;
    assign tick = cnt >= cur_thr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cur_thr <= RESET_THR;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            cur_thr <= load ? load_thr : cur_thr;
        end
    end
endmodule

// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: arbitrates threshold changes, applies them at a period boundary and
// holds div_ready low for a settle window so downstream FSMs never see a runt period.
module clk_div_sequencer
    import clk_div_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 24,
    parameter logic [WIDTH-1:0] RESET_THR    = 24'd100,
    parameter int               SETTLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] thr0,
    input  logic [WIDTH-1:0] thr1,
    output logic [1:0]       ack,
    output logic             tick,
    output logic [WIDTH-1:0] cur_thr,
    output logic             div_ready,
    output logic             busy
);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    state_t          state, state_nx;
    logic            gnt_id, gnt_nx, rr_last, take, apply, settle_done;
    logic [WIDTH-1:0] pend_thr;
    logic [SW-1:0]   settle_cnt;
    clk_div_counter #(.WIDTH(WIDTH), .RESET_THR(RESET_THR)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (apply),
        .load_thr (pend_thr),
        .tick     (tick),
        .cur_thr  (cur_thr)
    );
    assign busy = state != IDLE;
    // On a tie the requester that did not win last time is granted.
    assign gnt_nx = (&req) ? ~rr_last : req[REQ_CFG];
    always_comb begin
        ack         = '0;
        take        = state == IDLE && |req;
        apply       = state == WAIT_WRAP && tick;
        settle_done = state == SETTLE && tick && settle_cnt == '0;
        ack[gnt_id] = apply;
        state_nx    = take ? WAIT_WRAP : apply ? SETTLE : settle_done ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_id     <= REQ_HOST;
            rr_last    <= REQ_CFG;
            pend_thr   <= RESET_THR;
            settle_cnt <= '0;
            div_ready  <= 1'b1;
        end else begin
            state <= state_nx;
            if (take) begin
                gnt_id   <= gnt_nx;
                rr_last  <= gnt_nx;
                pend_thr <= gnt_nx ? thr1 : thr0;
            end
            if (apply) begin
                div_ready  <= 1'b0;
                settle_cnt <= SW'(SETTLE_TICKS - 1);
            end else if (state == SETTLE && tick) begin
                div_ready  <= settle_done;
                settle_cnt <= settle_done ? settle_cnt : settle_cnt - 1'b1;
            end
        end
    end
endmodule
